// File: rtl/truth_table_scanner.sv
// truth_table_scanner: walks a 4-input SoP block through all 16 minterms,
// captures the returned F into a truth table, counts the ones and compares
// the result against a golden table latched when the scan starts.
module truth_table_scanner #(
   parameter int SETTLE_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] expected,
   input  logic        f_in,
   output logic        a,
   output logic        b,
   output logic        c,
   output logic        d,
   output logic        busy,
   output logic        done,
   output logic [15:0] table_out,
   output logic [4:0]  minterm_count,
   output logic        match
);

   localparam logic [3:0] SETTLE_LIM = 4'(SETTLE_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_DONE
   } state_t;

   state_t      state_q;
   logic [3:0]  idx_q;
   logic [3:0]  settle_q;
   logic [15:0] table_q;
   logic [15:0] table_d;
   logic [4:0]  count_q;
   logic [4:0]  count_d;
   logic [15:0] exp_q;
   logic        match_q;
   logic        busy_q;
   logic        done_q;

   // Table and count as they will look once the current f_in is captured;
   // match uses this so the last minterm is included in the done cycle.
   always_comb begin
      table_d        = table_q;
      table_d[idx_q] = f_in;
      count_d        = count_q + {4'd0, f_in};
   end

   // Scan sequencer: index/settle counters, capture, and registered status.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         idx_q    <= 4'd0;
         settle_q <= 4'd0;
         table_q  <= 16'd0;
         count_q  <= 5'd0;
         exp_q    <= 16'd0;
         match_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q  <= S_SCAN;
                  busy_q   <= 1'b1;
                  idx_q    <= 4'd0;
                  settle_q <= 4'd0;
                  table_q  <= 16'd0;
                  count_q  <= 5'd0;
                  match_q  <= 1'b0;
                  exp_q    <= expected;
               end
            end
            S_SCAN: begin
               // Equality test is enough: settle counts up from zero.
               if (settle_q != SETTLE_LIM) begin
                  settle_q <= settle_q + 4'd1;
               end else begin
                  table_q  <= table_d;
                  count_q  <= count_d;
                  settle_q <= 4'd0;
                  if (idx_q == 4'hF) begin
                     // Index parks at 15 for the done cycle; no second pass.
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     match_q <= (table_d == exp_q);
                  end else begin
                     idx_q <= idx_q + 4'd1;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
               idx_q   <= 4'd0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign a             = idx_q[3];
   assign b             = idx_q[2];
   assign c             = idx_q[1];
   assign d             = idx_q[0];
   assign busy          = busy_q;
   assign done          = done_q;
   assign table_out     = table_q;
   assign minterm_count = count_q;
   assign match         = match_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner: one instance with no settle slack
// driven by a table-based SoP model, one with two settle cycles and F = d.
module tb_truth_table_scanner;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        start0, start2;
   logic [15:0] exp0, exp2;
   logic [15:0] tbl0;
   logic        f0, f2;
   logic        a0, b0, c0, d0, busy0, done0, match0;
   logic        a2, b2, c2, d2, busy2, done2, match2;
   logic [15:0] tab0, tab2;
   logic [4:0]  cnt0, cnt2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Downstream SoP block models (purely combinational)
   assign f0 = tbl0[{a0, b0, c0, d0}];
   assign f2 = d2;

   truth_table_scanner #(.SETTLE_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .expected(exp0), .f_in(f0),
      .a(a0), .b(b0), .c(c0), .d(d0), .busy(busy0), .done(done0),
      .table_out(tab0), .minterm_count(cnt0), .match(match0)
   );

   truth_table_scanner #(.SETTLE_CYCLES(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .expected(exp2), .f_in(f2),
      .a(a2), .b(b2), .c(c2), .d(d2), .busy(busy2), .done(done2),
      .table_out(tab2), .minterm_count(cnt2), .match(match2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start0 = 1'b0; start2 = 1'b0;
      exp0 = 16'h0; exp2 = 16'h0; tbl0 = 16'h0;
      repeat (3) step();
      rst_n = 1'b1;
      step();
      checks++;
      if ({a0, b0, c0, d0, busy0, done0, tab0, cnt0, match0} !== 29'd0) begin
         errors++;
         $display("FAIL reset_dut0: got abcd=%b busy=%b done=%b tab=%h cnt=%0d match=%b required all zero",
                  {a0, b0, c0, d0}, busy0, done0, tab0, cnt0, match0);
      end
      checks++;
      if ({a2, b2, c2, d2, busy2, done2, tab2, cnt2, match2} !== 29'd0) begin
         errors++;
         $display("FAIL reset_dut2: got abcd=%b busy=%b done=%b tab=%h cnt=%0d match=%b required all zero",
                  {a2, b2, c2, d2}, busy2, done2, tab2, cnt2, match2);
      end
   endtask

   // Full scan on dut0 with checks on stepping, done cycle and hold afterwards
   task automatic scan0(input logic [15:0] tbl, input logic [15:0] expv,
                        input logic [15:0] want_tab, input logic [4:0] want_cnt,
                        input logic want_m, input string name);
      tbl0 = tbl; exp0 = expv; start0 = 1'b1;
      step();
      start0 = 1'b0;
      checks++;
      if (tab0 !== 16'h0 || cnt0 !== 5'd0 || match0 !== 1'b0) begin
         errors++;
         $display("FAIL %s_clear: got tab=%h cnt=%0d match=%b required 0000 0 0", name, tab0, cnt0, match0);
      end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if ({a0, b0, c0, d0} !== 4'(i) || busy0 !== 1'b1 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL %s_step%0d: got abcd=%b busy=%b done=%b required abcd=%b busy=1 done=0",
                     name, i, {a0, b0, c0, d0}, busy0, done0, 4'(i));
         end
         step();
      end
      checks++;
      if (done0 !== 1'b1 || busy0 !== 1'b0 || tab0 !== want_tab || cnt0 !== want_cnt || match0 !== want_m) begin
         errors++;
         $display("FAIL %s_done: got done=%b busy=%b tab=%h cnt=%0d match=%b required done=1 busy=0 tab=%h cnt=%0d match=%b",
                  name, done0, busy0, tab0, cnt0, match0, want_tab, want_cnt, want_m);
      end
      step();
      checks++;
      if (done0 !== 1'b0 || {a0, b0, c0, d0} !== 4'b0000 || tab0 !== want_tab ||
          cnt0 !== want_cnt || match0 !== want_m) begin
         errors++;
         $display("FAIL %s_hold: got done=%b abcd=%b tab=%h cnt=%0d match=%b required done=0 abcd=0000 tab=%h cnt=%0d match=%b",
                  name, done0, {a0, b0, c0, d0}, tab0, cnt0, match0, want_tab, want_cnt, want_m);
      end
   endtask

   task automatic test_sop_scan();
      scan0(16'hD153, 16'hD153, 16'hD153, 5'd8, 1'b1, "sop");
   endtask

   task automatic test_constant();
      scan0(16'h0000, 16'h0000, 16'h0000, 5'd0, 1'b1, "tied0");
      scan0(16'hFFFF, 16'h0000, 16'hFFFF, 5'd16, 1'b0, "tied1");
   endtask

   task automatic test_settle();
      exp2 = 16'hAAAA; start2 = 1'b1;
      step();
      start2 = 1'b0;
      for (int n = 0; n < 48; n++) begin
         checks++;
         if ({a2, b2, c2, d2} !== 4'(n / 3) || busy2 !== 1'b1 || done2 !== 1'b0) begin
            errors++;
            $display("FAIL settle_n%0d: got abcd=%b busy=%b done=%b required abcd=%b busy=1 done=0",
                     n, {a2, b2, c2, d2}, busy2, done2, 4'(n / 3));
         end
         step();
      end
      checks++;
      if (done2 !== 1'b1 || tab2 !== 16'hAAAA || cnt2 !== 5'd8 || match2 !== 1'b1) begin
         errors++;
         $display("FAIL settle_done: got done=%b tab=%h cnt=%0d match=%b required done=1 tab=aaaa cnt=8 match=1",
                  done2, tab2, cnt2, match2);
      end
      step();
   endtask

   task automatic test_mid_reset();
      int dones;
      tbl0 = 16'hD153; exp0 = 16'hD153; start0 = 1'b1;
      step();
      start0 = 1'b0;
      repeat (7) step();
      checks++;
      if ({a0, b0, c0, d0} !== 4'd7 || busy0 !== 1'b1) begin
         errors++;
         $display("FAIL midrst_pre: got abcd=%b busy=%b required abcd=0111 busy=1", {a0, b0, c0, d0}, busy0);
      end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      checks++;
      if ({a0, b0, c0, d0, busy0, done0, tab0, cnt0, match0} !== 29'd0) begin
         errors++;
         $display("FAIL midrst_clear: got abcd=%b busy=%b done=%b tab=%h cnt=%0d match=%b required all zero",
                  {a0, b0, c0, d0}, busy0, done0, tab0, cnt0, match0);
      end
      dones = 0;
      for (int n = 0; n < 20; n++) begin
         if (done0 === 1'b1 || busy0 === 1'b1) dones++;
         step();
      end
      checks++;
      if (dones !== 0) begin
         errors++;
         $display("FAIL midrst_nodone: got %0d busy/done cycles required 0", dones);
      end
      scan0(16'hD153, 16'hD153, 16'hD153, 5'd8, 1'b1, "after_rst");
   endtask

   task automatic test_back_to_back();
      logic [3:0] want_idx;
      tbl0 = 16'hD153; exp0 = 16'hD153; start0 = 1'b1;
      step();
      for (int n = 0; n < 54; n++) begin
         want_idx = ((n % 18) < 16) ? 4'(n % 18) : ((n % 18) == 16 ? 4'hF : 4'h0);
         checks++;
         if (busy0 !== ((n % 18) < 16) || done0 !== ((n % 18) == 16) || {a0, b0, c0, d0} !== want_idx) begin
            errors++;
            $display("FAIL b2b_n%0d: got busy=%b done=%b abcd=%b required busy=%b done=%b abcd=%b",
                     n, busy0, done0, {a0, b0, c0, d0}, (n % 18) < 16, (n % 18) == 16, want_idx);
         end
         step();
      end
      start0 = 1'b0;
      repeat (20) step();
   endtask

   task automatic test_expected_latch();
      tbl0 = 16'hD153; exp0 = 16'hD153; start0 = 1'b1;
      step();
      start0 = 1'b0;
      repeat (5) step();
      exp0 = 16'h0000;
      repeat (11) step();
      checks++;
      if (done0 !== 1'b1 || tab0 !== 16'hD153 || match0 !== 1'b1) begin
         errors++;
         $display("FAIL exp_latch: got done=%b tab=%h match=%b required done=1 tab=d153 match=1",
                  done0, tab0, match0);
      end
      step();
      checks++;
      if (match0 !== 1'b1) begin
         errors++;
         $display("FAIL exp_latch_hold: got match=%b required 1", match0);
      end
   endtask

   initial begin
      test_reset();
      test_sop_scan();
      test_constant();
      test_settle();
      test_mid_reset();
      test_back_to_back();
      test_expected_latch();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/truth_table_scanner.md
Name: truth_table_scanner

Overview:
Sequencer that sits directly upstream of a 4-input combinational SoP function block. It drives all 16 input combinations onto the block's inputs a, b, c, d and captures the returned F into a 16-bit truth-table register. It counts the minterms and compares the captured table against a golden table. It is used for self-check of SoP blocks in the lab/recovery designs.

Parameters:
SETTLE_CYCLES, 0, extra wait cycles per combination before f_in is sampled (0..15); each combination occupies SETTLE_CYCLES+1 cycles.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous reset, active-low
start  input  1  scan request, sampled only in IDLE
expected  input  16  golden truth table, bit i = F for minterm i; latched when start is accepted
f_in  input  1  F output of the downstream SoP block (combinational from a,b,c,d)
a  output  1  drive to SoP input a (MSB of minterm index)
b  output  1  drive to SoP input b
c  output  1  drive to SoP input c
d  output  1  drive to SoP input d (LSB of minterm index)
busy  output  1  high in SCAN state
done  output  1  one-cycle pulse when scan completes
table_out  output  16  captured truth table, bit i = f_in sampled with {a,b,c,d}=i
minterm_count  output  5  number of 1 bits in table_out (0..16)
match  output  1  table_out == latched expected, valid from done pulse onward

Behaviour:
- Reset (rst_n=0 at rising edge): state=IDLE; a,b,c,d=0; busy=0; done=0; table_out=0; minterm_count=0; match=0; index, settle counter and latched expected cleared. Reset in any state, including mid-scan, aborts immediately, with no partial results retained.
- {a,b,c,d} is driven directly from a registered 4-bit index: a=idx[3], d=idx[0]. There are no glitches from this block.
- States: IDLE, SCAN, DONE.
- IDLE: outputs hold the previous table_out, minterm_count and match; {a,b,c,d}=0000.
  - start=1 at an edge: state<=SCAN; idx<=0; settle<=0; table_out<=0; minterm_count<=0; match<=0; exp_q<=expected.
- SCAN: busy=1.
  - If settle<SETTLE_CYCLES: settle increments, with no sample.
  - Otherwise, on that edge: table_out[idx]<=f_in; minterm_count increments if f_in=1; settle<=0.
    - If idx==15: state<=DONE. The index does not wrap into another pass.
    - Else idx<=idx+1.
  - start is ignored in SCAN.
- DONE: lasts exactly one cycle; done=1; busy=0; match=(table_out==exp_q) registered on entry to DONE so it is valid in the done cycle. Next state is IDLE.
  - start asserted during DONE is ignored; it must be re-asserted in IDLE.
  - {a,b,c,d} return to 0000 on entry to IDLE.
- Timing with SETTLE_CYCLES=0: start accepted at edge E0. Combination i is driven during the cycle after edge E0+i and sampled at edge E0+i+1. done is high in the cycle after edge E0+16. Total 17 cycles from start accept to done.
- General timing: done rises after 16*(SETTLE_CYCLES+1)+1 edges.
- Results (table_out, minterm_count, match) remain stable until the next accepted start or reset.
- f_in is assumed combinational from a,b,c,d with no register. The SETTLE_CYCLES slack covers slower paths.

Test Plan:
1. SETTLE_CYCLES=0, f_in = SoP with minterms {0,1,4,6,8,12,14,15}, expected=16'hD153, pulse start → 17 cycles later done=1, table_out=16'hD153, minterm_count=8, match=1; a..d step 0000→1111 once.
2. f_in tied 0, expected=16'h0000 → table_out=16'h0000, minterm_count=0, match=1; f_in tied 1, expected=16'h0000 → table_out=16'hFFFF, count=16, match=0.
3. f_in=d, SETTLE_CYCLES=2, expected=16'hAAAA → each {a,b,c,d} value held 3 cycles, done after 49 edges, table_out=16'hAAAA, count=8, match=1.
4. Reset mid-scan: start, drop rst_n for one edge when idx=7 → next cycle state IDLE, all outputs zero, no done pulse; a following start produces a full correct scan.
5. start held high continuously → done pulses once every 18 cycles; start pulses during SCAN/DONE produce no restart; busy=1 only across the 16 SCAN cycles.
6. Change expected mid-scan from 16'hD153 to 16'h0000 with SoP of test 1 → match=1, because expected is latched at start.
